stonyman_scan_ctrl: RTL and testbench

- Frame sequencer for the Stonyman image sensor on the capture fabric.
- Drives the sensor pointer/value strobes (resp, incp, resv, incv) and the amplifier strobe (inphi).
- Walks the pixel array row by row and, for each pixel, requests one conversion from the SPI ADC reader.
- Emits each converted sample, tagged with its row and column, to the capture buffer.

---
 rtl/stonyman_scan_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_stonyman_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stonyman_scan_ctrl.sv
// Frame sequencer for the Stonyman sensor: walks rows/cols, strobes the sensor, requests one ADC conversion per pixel.
// Latency: sample emitted one cycle after adc_ack; each strobe state takes 2*PULSE_CYCLES+1 cycles.
// Backpressure: adc_req is held until adc_ack (no timeout); the capture buffer side has no stall input.
module stonyman_scan_ctrl #(
  parameter int ROWS          = 112,
  parameter int COLS          = 112,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_capture,
  input  logic       abort,
  output logic       adc_req,
  input  logic       adc_ack,
  input  logic [9:0] adc_data,
  output logic       pix_valid,
  output logic [9:0] pix_data,
  output logic [6:0] pix_row,
  output logic [6:0] pix_col,
  output logic       busy,
  output logic       frame_done,
  output logic       resp,
  output logic       incp,
  output logic       resv,
  output logic       incv,
  output logic       inphi
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PTR_RST,
    S_ROW_PTR,
    S_ROW_VAL,
    S_COL_PTR,
    S_COL_VAL,
    S_INC_COL,
    S_SETTLE,
    S_PHI,
    S_ADC_REQ,
    S_EMIT
  } state_t;

  localparam int            CW         = 16;
  localparam logic [CW-1:0] PULSE_LEN  = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] STROBE_END = CW'(2 * PULSE_CYCLES);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [6:0]    LAST_ROW   = 7'(ROWS - 1);
  localparam logic [6:0]    LAST_COL   = 7'(COLS - 1);

  // Strobe bit order: {resp, incp, resv, incv, inphi}
  localparam logic [4:0] M_RESP  = 5'b10000;
  localparam logic [4:0] M_INCP  = 5'b01000;
  localparam logic [4:0] M_RESV  = 5'b00100;
  localparam logic [4:0] M_INCV  = 5'b00010;
  localparam logic [4:0] M_INPHI = 5'b00001;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [6:0]    row_q;
  logic [6:0]    col_q;
  logic [4:0]    strobe_q;
  logic          adc_req_q;
  logic          pix_valid_q;
  logic [9:0]    pix_data_q;
  logic [6:0]    pix_row_q;
  logic [6:0]    pix_col_q;
  logic          busy_q;
  logic          frame_done_q;

  // Which sensor line a strobe state pulses; the first row resets the value line, later rows step it.
  function automatic logic [4:0] strobe_mask(input state_t st, input logic [6:0] row);
    case (st)
      S_PTR_RST: strobe_mask = M_RESP;
      S_ROW_PTR: strobe_mask = M_INCP;
      S_ROW_VAL: strobe_mask = (row == 7'd0) ? M_RESV : M_INCV;
      S_COL_PTR: strobe_mask = M_RESP;
      S_COL_VAL: strobe_mask = M_RESV;
      S_INC_COL: strobe_mask = M_INCV;
      S_PHI:     strobe_mask = M_INPHI;
      default:   strobe_mask = 5'b00000;
    endcase
  endfunction

  // Successor of each strobe state once its high+low window has elapsed.
  function automatic state_t strobe_next(input state_t st);
    case (st)
      S_PTR_RST: strobe_next = S_ROW_PTR;
      S_ROW_PTR: strobe_next = S_ROW_VAL;
      S_ROW_VAL: strobe_next = S_COL_PTR;
      S_COL_PTR: strobe_next = S_COL_VAL;
      S_COL_VAL: strobe_next = S_SETTLE;
      S_INC_COL: strobe_next = S_SETTLE;
      S_PHI:     strobe_next = S_ADC_REQ;
      default:   strobe_next = S_IDLE;
    endcase
  endfunction

  // Frame sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      strobe_q     <= '0;
      adc_req_q    <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_row_q    <= '0;
      pix_col_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (abort && busy_q) begin
      // Abort drops the frame silently; sample outputs keep their last values.
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      strobe_q     <= '0;
      adc_req_q    <= 1'b0;
      pix_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_capture) begin
            state_q <= S_PTR_RST;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        S_PTR_RST, S_ROW_PTR, S_ROW_VAL, S_COL_PTR, S_COL_VAL, S_INC_COL, S_PHI: begin
          // cnt 0: entry, 1..P: strobe high, P+1..2P: strobe low, then advance.
          if (cnt_q == STROBE_END) begin
            cnt_q   <= '0;
            state_q <= strobe_next(state_q);
            if (state_q == S_PHI) begin
              adc_req_q <= 1'b1;
            end
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            strobe_q <= (cnt_q < PULSE_LEN) ? strobe_mask(state_q, row_q) : 5'b00000;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_END) begin
            cnt_q   <= '0;
            state_q <= S_PHI;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ADC_REQ: begin
          if (adc_ack) begin
            adc_req_q   <= 1'b0;
            pix_valid_q <= 1'b1;
            pix_data_q  <= adc_data;
            pix_row_q   <= row_q;
            pix_col_q   <= col_q;
            state_q     <= S_EMIT;
          end
        end
        S_EMIT: begin
          cnt_q <= '0;
          if (col_q != LAST_COL) begin
            col_q   <= col_q + 7'd1;
            state_q <= S_INC_COL;
          end else if (row_q != LAST_ROW) begin
            row_q   <= row_q + 7'd1;
            col_q   <= '0;
            state_q <= S_ROW_PTR;
          end else begin
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign resp       = strobe_q[4];
  assign incp       = strobe_q[3];
  assign resv       = strobe_q[2];
  assign incv       = strobe_q[1];
  assign inphi      = strobe_q[0];
  assign adc_req    = adc_req_q;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_row    = pix_row_q;
  assign pix_col    = pix_col_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_stonyman_scan_ctrl.sv
// Bench for stonyman_scan_ctrl: random ADC latency/data, spurious acks and starts, abort and mid-frame reset.
// Expected samples come from a raster-order index model and the data the bench itself returned as the ADC.
// Strobe counts are compared against closed-form per-frame totals.
module tb_stonyman_scan_ctrl;

  localparam int ROWS   = 2;
  localparam int COLS   = 3;
  localparam int PULSE  = 1;
  localparam int SETTLE = 2;
  localparam int NPIX   = ROWS * COLS;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_capture = 1'b0;
  logic       abort = 1'b0;
  logic       adc_ack = 1'b0;
  logic [9:0] adc_data = '0;
  logic       adc_req, pix_valid, busy, frame_done;
  logic [9:0] pix_data;
  logic [6:0] pix_row, pix_col;
  logic       resp, incp, resv, incv, inphi;

  always #5 clk = ~clk;

  stonyman_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .PULSE_CYCLES(PULSE), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_capture(start_capture), .abort(abort),
    .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .busy(busy), .frame_done(frame_done),
    .resp(resp), .incp(incp), .resv(resv), .incv(incv), .inphi(inphi)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Monitor / model state
  int         n_resp, n_incp, n_resv, n_incv, n_inphi, n_pix, n_done;
  int         strobe_viol, order_viol;
  int         exp_idx;
  logic [9:0] ackq[$];
  logic [4:0] prev_str = '0;
  bit         phi_seen, prev_req, ack_taken;
  int         req_run, last_req_len, cur_delay;
  int         ack_delay = 3;
  bit         spur_en, start_spam;
  bit         abort_armed, abort_fired;
  int         abort_idx = 3;

  task automatic clear_model();
    n_resp = 0; n_incp = 0; n_resv = 0; n_incv = 0; n_inphi = 0; n_pix = 0; n_done = 0;
    strobe_viol = 0; order_viol = 0; exp_idx = 0; ackq.delete();
    phi_seen = 0; req_run = 0;
  endtask

  // One cycle: observe outputs at negedge, then drive inputs for the next posedge.
  task automatic tick();
    logic [4:0] s;
    logic [9:0] d;
    @(negedge clk);
    s = {resp, incp, resv, incv, inphi};
    n_resp += int'(resp); n_incp += int'(incp); n_resv += int'(resv);
    n_incv += int'(incv); n_inphi += int'(inphi);
    if ($countones(s) > 1) strobe_viol++;
    if (s != 5'b0 && prev_str != 5'b0) strobe_viol++;
    prev_str = s;
    if (inphi) phi_seen = 1;
    if (adc_req && !prev_req) begin
      if (!phi_seen) order_viol++;
      phi_seen = 0;
      cur_delay = (ack_delay != 0) ? ack_delay : int'($urandom_range(1, 6));
    end
    if (adc_req) req_run++;
    else if (prev_req) begin
      last_req_len = req_run;
      req_run = 0;
    end
    chk("pix_timing", {31'b0, pix_valid}, {31'b0, ack_taken});
    if (pix_valid === 1'b1) begin
      n_pix++;
      if (ackq.size() == 0) chk("pix_unexpected", 1, 0);
      else begin
        d = ackq.pop_front();
        chk("pix_data", {22'b0, pix_data}, {22'b0, d});
        chk("pix_row", {25'b0, pix_row}, exp_idx / COLS);
        chk("pix_col", {25'b0, pix_col}, exp_idx % COLS);
      end
      exp_idx++;
    end
    if (frame_done) n_done++;
    prev_req = adc_req;
    // drive
    ack_taken = 0; adc_ack = 0; start_capture = 0; abort = 0;
    if (abort_armed && adc_req && exp_idx == abort_idx) begin
      abort = 1; abort_armed = 0; abort_fired = 1;
      adc_ack = 1; adc_data = 10'h2AA;  // in-flight ack that must be dropped
    end else if (adc_req && req_run == cur_delay) begin
      adc_ack = 1; adc_data = 10'($urandom); ackq.push_back(adc_data); ack_taken = 1;
    end else if (spur_en && !adc_req && $urandom_range(0, 3) == 0) begin
      adc_ack = 1; adc_data = 10'h3FF;
    end
    if (start_spam && busy && $urandom_range(0, 7) == 0) start_capture = 1;
  endtask

  task automatic run_frame(input string tag);
    int t;
    clear_model();
    start_capture = 1;
    tick();
    chk({tag, "_busy_start"}, {31'b0, busy}, 1);
    t = 0;
    while (n_done == 0 && t < 5000) begin
      tick();
      t++;
    end
    chk({tag, "_done_in_time"}, (t < 5000) ? 1 : 0, 1);
    chk({tag, "_busy_at_done"}, {31'b0, busy}, 0);
    repeat (3) tick();
    chk({tag, "_frame_done"}, n_done, 1);
    chk({tag, "_busy_after"}, {31'b0, busy}, 0);
    chk({tag, "_pix"}, n_pix, NPIX);
    chk({tag, "_resp"}, n_resp, 1 + ROWS);
    chk({tag, "_incp"}, n_incp, ROWS);
    chk({tag, "_resv"}, n_resv, 1 + ROWS);
    chk({tag, "_incv"}, n_incv, (ROWS - 1) + ROWS * (COLS - 1));
    chk({tag, "_inphi"}, n_inphi, NPIX);
    chk({tag, "_strobe_rules"}, strobe_viol, 0);
    chk({tag, "_phi_before_req"}, order_viol, 0);
  endtask

  initial begin
    int t;
    clear_model();
    repeat (3) tick();
    chk("reset_strobes", {27'b0, resp, incp, resv, incv, inphi}, 0);
    chk("reset_ctrl", {28'b0, adc_req, pix_valid, busy, frame_done}, 0);
    chk("reset_pix_data", {22'b0, pix_data}, 0);
    chk("reset_pix_pos", {18'b0, pix_row, pix_col}, 0);
    reset_n = 1;
    tick();

    ack_delay = 3;
    run_frame("base");
    chk("base_req_len", last_req_len, 3);

    ack_delay = 0; spur_en = 1; start_spam = 1;
    repeat (3) run_frame("rand");

    spur_en = 0; start_spam = 0; ack_delay = 50;
    run_frame("slow");
    chk("slow_req_len", last_req_len, 50);

    // Abort while pixel (1,0) waits on the ADC
    ack_delay = 0;
    clear_model();
    abort_armed = 1; abort_fired = 0;
    start_capture = 1;
    t = 0;
    while (!abort_fired && t < 5000) begin
      tick();
      t++;
    end
    chk("abort_reached", {31'b0, abort_fired}, 1);
    tick();
    chk("abort_strobes", {27'b0, resp, incp, resv, incv, inphi}, 0);
    chk("abort_ctrl", {28'b0, adc_req, pix_valid, busy, frame_done}, 0);
    repeat (10) tick();
    chk("abort_no_done", n_done, 0);
    chk("abort_pix_before", n_pix, 3);
    run_frame("post_abort");

    // One-cycle reset in the middle of row 0
    ack_delay = 2;
    clear_model();
    start_capture = 1;
    t = 0;
    while (exp_idx < 1 && t < 5000) begin
      tick();
      t++;
    end
    chk("rst_reached", (t < 5000) ? 1 : 0, 1);
    repeat (2) tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("rst_strobes", {27'b0, resp, incp, resv, incv, inphi}, 0);
    chk("rst_ctrl", {28'b0, adc_req, pix_valid, busy, frame_done}, 0);
    chk("rst_pix_data", {22'b0, pix_data}, 0);
    chk("rst_pix_pos", {18'b0, pix_row, pix_col}, 0);
    clear_model();
    spur_en = 1;
    repeat (12) tick();
    spur_en = 0;
    tick();
    chk("rst_late_ack_pix", n_pix, 0);
    chk("rst_idle_busy", {31'b0, busy}, 0);
    run_frame("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
